// File: rtl/cofi_ctrl.sv
// Frame-synchronous dither-blend sequencer: latches blend config at frame boundaries,
// counts per-frame dither-pattern hits and runs a hysteresis FSM for automatic force-blend.
module cofi_ctrl #(
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned THRESH_ON  = 4096,
  parameter int unsigned THRESH_OFF = 1024,
  parameter int unsigned ON_FRAMES  = 2,
  parameter int unsigned OFF_FRAMES = 8,
  parameter int unsigned DIFF_MAX   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pixel,
  input  logic             hblank,
  input  logic             vblank,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_reduced,
  output logic             force_blend,
  output logic             diff_blend,
  output logic             reduced,
  output logic             auto_on,
  output logic [CNT_W-1:0] last_count
);

  // state    | meaning
  // S_OFF    | auto blend disabled, waiting for a dithered frame
  // S_ARM    | counting consecutive dithered frames toward enable
  // S_ON     | auto blend enabled
  // S_DISARM | counting consecutive clean frames toward disable
  typedef enum logic [1:0] {S_OFF, S_ARM, S_ON, S_DISARM} state_t;

  localparam int unsigned STK_MAX = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
  localparam int unsigned STK_W   = $clog2(STK_MAX + 1);
  localparam logic [STK_W-1:0] ON_K  = STK_W'(ON_FRAMES);
  localparam logic [STK_W-1:0] OFF_K = STK_W'(OFF_FRAMES);
  localparam logic [1:0] MODE_AUTO = 2'd3;

  state_t             state_q, state_d, base_state;
  logic [STK_W-1:0]   streak_q, streak_d, base_streak, streak_inc;
  logic               vblank_q, vblank_d;
  logic [1:0]         valid_q, valid_d;
  logic [23:0]        p1_q, p1_d, p2_q, p2_d, pix;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]   last_count_q, last_count_d;
  logic [1:0]         mode_q, mode_d;
  logic               reduced_q, reduced_d;
  logic               force_q, force_d;
  logic               diff_q, diff_d;
  logic               frame_valid_q, frame_valid_d;
  logic               active, fb, hit, dith, clean, auto_next;

  function automatic logic near(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return (d != 8'd0) && (32'(d) <= DIFF_MAX);
  endfunction

  always_comb begin
    pix        = {red, green, blue};
    active     = !hblank && !vblank;
    fb         = ce_pixel && vblank && !vblank_q;
    hit        = active && (valid_q == 2'd2) && (p2_q == pix) &&
                 near(p1_q[23:16], red) && near(p1_q[15:8], green) && near(p1_q[7:0], blue);
    cnt_inc    = (hit && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    dith       = 32'(cnt_inc) >= THRESH_ON;
    clean      = 32'(cnt_inc) < THRESH_OFF;

    vblank_d      = vblank_q;
    valid_d       = valid_q;
    p1_d          = p1_q;
    p2_d          = p2_q;
    cnt_d         = cnt_q;
    last_count_d  = last_count_q;
    mode_d        = mode_q;
    reduced_d     = reduced_q;
    force_d       = force_q;
    diff_d        = diff_q;
    frame_valid_d = frame_valid_q;
    state_d       = state_q;
    streak_d      = streak_q;
    base_state    = state_q;
    base_streak   = streak_q;
    streak_inc    = streak_q;
    auto_next     = 1'b0;

    if (ce_pixel) begin
      vblank_d = vblank;
      if (!active) begin
        valid_d = 2'd0;
      end else begin
        if (valid_q != 2'd2) valid_d = valid_q + 2'd1;
        p1_d = pix;
        p2_d = p1_q;
      end
      cnt_d = cnt_inc;

      if (fb) begin
        last_count_d  = cnt_inc;
        cnt_d         = '0;
        mode_d        = cfg_mode;
        reduced_d     = cfg_reduced;
        frame_valid_d = 1'b1;

        // Entering auto mode always restarts the hysteresis from scratch.
        if (cfg_mode == MODE_AUTO && mode_q != MODE_AUTO) begin
          base_state  = S_OFF;
          base_streak = '0;
        end
        streak_inc = base_streak + STK_W'(1);
        state_d    = base_state;
        streak_d   = base_streak;

        if (cfg_mode == MODE_AUTO && frame_valid_q) begin
          unique case (base_state)
            S_OFF: if (dith) begin
              if (ON_K == STK_W'(1)) begin state_d = S_ON;  streak_d = '0;         end
              else                   begin state_d = S_ARM; streak_d = STK_W'(1); end
            end
            S_ARM: if (dith) begin
              if (streak_inc >= ON_K) begin state_d = S_ON; streak_d = '0;  end
              else                          streak_d = streak_inc;
            end else begin
              state_d  = S_OFF;
              streak_d = '0;
            end
            S_ON: if (clean) begin
              if (OFF_K == STK_W'(1)) begin state_d = S_OFF;    streak_d = '0;        end
              else                    begin state_d = S_DISARM; streak_d = STK_W'(1); end
            end
            S_DISARM: if (clean) begin
              if (streak_inc >= OFF_K) begin state_d = S_OFF; streak_d = '0; end
              else                           streak_d = streak_inc;
            end else begin
              state_d  = S_ON;
              streak_d = '0;
            end
            default: begin
              state_d  = S_OFF;
              streak_d = '0;
            end
          endcase
        end

        auto_next = (state_d == S_ON) || (state_d == S_DISARM);
        force_d   = 1'b0;
        diff_d    = 1'b0;
        unique case (cfg_mode)
          2'd1:    force_d = 1'b1;
          2'd2:    diff_d  = 1'b1;
          2'd3:    force_d = auto_next;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_OFF;
      streak_q      <= '0;
      vblank_q      <= 1'b0;
      valid_q       <= 2'd0;
      p1_q          <= '0;
      p2_q          <= '0;
      cnt_q         <= '0;
      last_count_q  <= '0;
      mode_q        <= 2'd0;
      reduced_q     <= 1'b0;
      force_q       <= 1'b0;
      diff_q        <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      vblank_q      <= vblank_d;
      valid_q       <= valid_d;
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      cnt_q         <= cnt_d;
      last_count_q  <= last_count_d;
      mode_q        <= mode_d;
      reduced_q     <= reduced_d;
      force_q       <= force_d;
      diff_q        <= diff_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign force_blend = force_q;
  assign diff_blend  = diff_q;
  assign reduced     = reduced_q;
  assign auto_on     = (state_q == S_ON) || (state_q == S_DISARM);
  assign last_count  = last_count_q;

endmodule

// File: tb/tb_cofi_ctrl.sv
// Directed bench for cofi_ctrl: one instance with lowered thresholds for the auto FSM,
// one with CNT_W = 4 and default thresholds, both fed the same pixel stream.
module tb_cofi_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_pixel, hblank, vblank;
  logic [7:0]  red, green, blue;
  logic [1:0]  cfg_mode;
  logic        cfg_reduced;

  logic        force_a, diff_a, reduced_a, auto_a;
  logic [19:0] lc_a;
  logic        force_b, diff_b, reduced_b, auto_b;
  logic [3:0]  lc_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cofi_ctrl #(
    .CNT_W(20), .THRESH_ON(100), .THRESH_OFF(10), .ON_FRAMES(2), .OFF_FRAMES(3), .DIFF_MAX(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue), .cfg_mode(cfg_mode), .cfg_reduced(cfg_reduced),
    .force_blend(force_a), .diff_blend(diff_a), .reduced(reduced_a), .auto_on(auto_a),
    .last_count(lc_a)
  );

  cofi_ctrl #(.CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .hblank(hblank), .vblank(vblank),
    .red(red), .green(green), .blue(blue), .cfg_mode(cfg_mode), .cfg_reduced(cfg_reduced),
    .force_blend(force_b), .diff_blend(diff_b), .reduced(reduced_b), .auto_on(auto_b),
    .last_count(lc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One ce_pixel cycle followed by an idle clk, so every register must also hold with ce low.
  task automatic step(input logic h, input logic v, input logic [7:0] val);
    hblank = h; vblank = v;
    red = val; green = val; blue = val;
    ce_pixel = 1'b1;
    @(posedge clk); #1;
    ce_pixel = 1'b0;
    @(posedge clk); #1;
  endtask

  // One line of n active grey pixels alternating 10 / hi, then hblank, then vblank (FB).
  task automatic frame(input int n, input logic [7:0] hi);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 8'd10 : hi);
    step(1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 8'd0);
    step(1'b0, 1'b1, 8'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hblank = 1'b0; vblank = 1'b0; ce_pixel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    red = '0; green = '0; blue = '0;
    cfg_mode = 2'd0; cfg_reduced = 1'b0;
    do_reset();
    check("rst_force", force_a, 0);
    check("rst_diff", diff_a, 0);
    check("rst_reduced", reduced_a, 0);
    check("rst_auto", auto_a, 0);
    check("rst_lc", lc_a, 0);

    // Mode 1 requested mid-frame must wait for the next FB.
    step(1'b0, 1'b0, 8'd10); step(1'b0, 1'b0, 8'd18); step(1'b0, 1'b0, 8'd10);
    step(1'b0, 1'b0, 8'd18); step(1'b0, 1'b0, 8'd10);
    cfg_mode = 2'd1; cfg_reduced = 1'b1;
    step(1'b1, 1'b0, 8'd0);
    check("midframe_force", force_a, 0);
    check("midframe_reduced", reduced_a, 0);
    frame(640, 8'd18);
    check("m1_force", force_a, 1);
    check("m1_diff", diff_a, 0);
    check("m1_reduced", reduced_a, 1);
    check("m1_lc", lc_a, 641);
    check("m1_lc_sat", lc_b, 15);

    frame(640, 8'd60);
    check("wide_step_lc", lc_a, 0);
    check("wide_step_lc_b", lc_b, 0);
    check("m1_hold_force", force_a, 1);
    frame(640, 8'd18);
    check("line_lc", lc_a, 638);
    check("line_lc_sat", lc_b, 15);

    cfg_mode = 2'd2;
    frame(640, 8'd18);
    check("m2_force", force_a, 0);
    check("m2_diff", diff_a, 1);

    // Auto mode from a fresh reset: FB1 partial, FB2 arms, FB3 enables.
    cfg_mode = 2'd3; cfg_reduced = 1'b0;
    do_reset();
    check("rst2_diff", diff_a, 0);
    check("rst2_lc", lc_a, 0);
    frame(640, 8'd18);
    check("fb1_auto", auto_a, 0);
    check("fb1_force", force_a, 0);
    frame(640, 8'd18);
    check("fb2_auto", auto_a, 0);
    check("fb2_force", force_a, 0);
    frame(640, 8'd18);
    check("fb3_auto", auto_a, 1);
    check("fb3_force", force_a, 1);
    check("fb3_auto_b", auto_b, 0);
    check("fb3_force_b", force_b, 0);

    frame(640, 8'd60);
    check("clean1_auto", auto_a, 1);
    frame(640, 8'd60);
    check("clean2_auto", auto_a, 1);
    frame(52, 8'd18);
    check("neutral_lc", lc_a, 50);
    check("neutral_auto", auto_a, 1);
    frame(640, 8'd60);
    check("reclean1_auto", auto_a, 1);
    frame(640, 8'd60);
    check("reclean2_auto", auto_a, 1);
    frame(640, 8'd60);
    check("reclean3_auto", auto_a, 0);
    check("reclean3_force", force_a, 0);

    cfg_reduced = 1'b1;
    frame(640, 8'd18);
    check("rearm_auto", auto_a, 0);
    frame(640, 8'd18);
    check("reon_auto", auto_a, 1);
    check("reon_reduced", reduced_a, 1);

    // Asynchronous reset in the middle of a frame while enabled.
    step(1'b0, 1'b0, 8'd10); step(1'b0, 1'b0, 8'd18); step(1'b0, 1'b0, 8'd10);
    reset_n = 1'b0;
    #1;
    check("async_force", force_a, 0);
    check("async_auto", auto_a, 0);
    check("async_reduced", reduced_a, 0);
    check("async_lc", lc_a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    frame(640, 8'd18);
    check("post_rst_fb1_auto", auto_a, 0);
    check("post_rst_fb1_lc", lc_a, 638);
    frame(640, 8'd18);
    check("post_rst_fb2_auto", auto_a, 0);
    frame(640, 8'd18);
    check("post_rst_fb3_auto", auto_a, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
